// File: rtl/tcdm_bank_rr_arbiter.sv
// Round-robin arbiter sharing one single-ported TCDM bank between NB_MST requesters,
// with address-map decode and 1-cycle response routing. Optional counters: TCDM_ARB_PERF_CNT_EN.

package mem_pkg;
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;
endpackage

module tcdm_bank_rr_arbiter #(
  parameter int unsigned NB_MST   = 4,
  parameter int unsigned NB_RULES = 2,
  parameter int unsigned MEM_AW   = 10
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NB_MST-1:0]                     mst_req_i,
  input  logic [NB_MST-1:0][31:0]               mst_add_i,
  input  logic [NB_MST-1:0]                     mst_wen_i,
  input  logic [NB_MST-1:0][3:0]                mst_be_i,
  input  logic [NB_MST-1:0][31:0]               mst_data_i,
  output logic [NB_MST-1:0]                     mst_gnt_o,
  output logic [NB_MST-1:0]                     mst_r_valid_o,
  output logic [NB_MST-1:0][31:0]               mst_r_data_o,
  output logic [NB_MST-1:0]                     mst_r_opc_o,
  input  mem_pkg::addr_map_rule_t [NB_RULES-1:0] rules_i,
`ifdef TCDM_ARB_PERF_CNT_EN
  input  logic                                  perf_clear_i,
  output logic [31:0]                           perf_gnt_cnt_o,
  output logic [31:0]                           perf_conf_cnt_o,
`endif
  output logic                                  mem_req_o,
  output logic                                  mem_we_o,
  output logic [MEM_AW-1:0]                     mem_addr_o,
  output logic [3:0]                            mem_be_o,
  output logic [31:0]                           mem_wdata_o,
  input  logic [31:0]                           mem_rdata_i
);

  localparam int unsigned IDX_W = (NB_MST > 1) ? $clog2(NB_MST) : 1;
  localparam logic [IDX_W:0] NB_MST_W = (IDX_W+1)'(NB_MST);

  logic [IDX_W-1:0] rr_q, rr_next;
  logic             resp_vld_q, resp_err_q, resp_rd_q;
  logic [IDX_W-1:0] resp_idx_q;

  // Arbitration: rotate the request vector so rr_q sits at bit 0, then pick the lowest set bit.
  logic [2*NB_MST-1:0] req_dbl_sh;
  logic [NB_MST-1:0]   req_rot;
  logic [IDX_W-1:0]    rot_off, win_idx;
  logic [IDX_W:0]      win_sum, win_inc;
  logic                gnt_any;

  assign req_dbl_sh = {mst_req_i, mst_req_i} >> rr_q;
  assign req_rot    = req_dbl_sh[NB_MST-1:0];

  always_comb begin
    rot_off = '0;
    for (int k = NB_MST-1; k >= 0; k--) begin
      if (req_rot[k]) rot_off = IDX_W'(k);
    end
  end

  assign gnt_any = (|mst_req_i) & ~rst_i;
  assign win_sum = {1'b0, rr_q} + {1'b0, rot_off};
  assign win_idx = (win_sum >= NB_MST_W) ? IDX_W'(win_sum - NB_MST_W) : win_sum[IDX_W-1:0];
  assign win_inc = {1'b0, win_idx} + (IDX_W+1)'(1);
  assign rr_next = (win_inc == NB_MST_W) ? '0 : win_inc[IDX_W-1:0];

  // Address decode of the winning request; lowest matching rule wins.
  logic [31:0] win_add, rule_base, word_off;
  logic        hit;

  assign win_add = mst_add_i[win_idx];

  always_comb begin
    hit       = 1'b0;
    rule_base = '0;
    for (int k = 0; k < NB_RULES; k++) begin
      if (!hit && (win_add >= rules_i[k].start_addr) && (win_add < rules_i[k].end_addr)) begin
        hit       = 1'b1;
        rule_base = rules_i[k].start_addr;
      end
    end
  end

  assign word_off = win_add - rule_base;

  logic mem_acc;
  assign mem_acc     = gnt_any & hit;
  assign mem_req_o   = mem_acc;
  assign mem_we_o    = mem_acc & ~mst_wen_i[win_idx];
  assign mem_addr_o  = mem_acc ? word_off[MEM_AW+1:2] : '0;
  assign mem_be_o    = mem_acc ? mst_be_i[win_idx] : '0;
  assign mem_wdata_o = mem_acc ? mst_data_i[win_idx] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      resp_vld_q <= 1'b0;
      resp_idx_q <= '0;
      resp_err_q <= 1'b0;
      resp_rd_q  <= 1'b0;
    end else begin
      if (gnt_any) rr_q <= rr_next;
      resp_vld_q <= gnt_any;
      resp_idx_q <= win_idx;
      resp_err_q <= gnt_any & ~hit;
      resp_rd_q  <= mst_wen_i[win_idx];
    end
  end

  // Read data is a shared bus; only reads that hit carry SRAM data.
  logic [31:0] rsp_data;
  assign rsp_data = (resp_vld_q && resp_rd_q && !resp_err_q) ? mem_rdata_i : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NB_MST; gi++) begin : g_port
      // A response still pending while reset is held is suppressed.
      logic sel_rsp;
      assign sel_rsp            = resp_vld_q & ~rst_i & (resp_idx_q == IDX_W'(gi));
      assign mst_gnt_o[gi]      = gnt_any & (win_idx == IDX_W'(gi));
      assign mst_r_valid_o[gi]  = sel_rsp;
      assign mst_r_opc_o[gi]    = sel_rsp & resp_err_q;
      assign mst_r_data_o[gi]   = rsp_data;
    end
  endgenerate

  logic [NB_RULES-1:0] unused_rule_idx;
  generate
    for (gi = 0; gi < NB_RULES; gi++) begin : g_rule_idx
      assign unused_rule_idx[gi] = ^rules_i[gi].idx;
    end
  endgenerate

  logic unused_bits;
  assign unused_bits = ^{word_off, req_dbl_sh, unused_rule_idx};

`ifdef TCDM_ARB_PERF_CNT_EN
  localparam int unsigned CNT_W = $clog2(NB_MST+1);

  logic [CNT_W-1:0] req_cnt, conf_inc;
  logic [31:0]      gnt_cnt_q, conf_cnt_q;
  logic [32:0]      gnt_sum, conf_sum;

  always_comb begin
    req_cnt = '0;
    for (int k = 0; k < NB_MST; k++) begin
      req_cnt = req_cnt + CNT_W'(mst_req_i[k]);
    end
  end

  assign conf_inc = (req_cnt >= CNT_W'(2)) ? (req_cnt - CNT_W'(1)) : '0;
  assign gnt_sum  = {1'b0, gnt_cnt_q} + 33'(gnt_any);
  assign conf_sum = {1'b0, conf_cnt_q} + 33'(conf_inc);

  always_ff @(posedge clk_i) begin
    if (rst_i || perf_clear_i) begin
      gnt_cnt_q  <= '0;
      conf_cnt_q <= '0;
    end else begin
      gnt_cnt_q  <= gnt_sum[32] ? '1 : gnt_sum[31:0];
      conf_cnt_q <= conf_sum[32] ? '1 : conf_sum[31:0];
    end
  end

  assign perf_gnt_cnt_o  = gnt_cnt_q;
  assign perf_conf_cnt_o = conf_cnt_q;
`endif

endmodule
